// File: rtl/ltssm_pkg.sv
// Shared definitions for the link-level LTSSM controller.
// Holds the substate encodings (0..13), the LPIF state encodings, the
// legal-successor map and small helpers for lane counting and rate selection.
package ltssm_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET          = 4'd0,
    DETECT_ACTIVE         = 4'd1,
    POLLING_ACTIVE        = 4'd2,
    POLLING_CONFIGURATION = 4'd3,
    CFG_LINK_WIDTH_START  = 4'd4,
    CFG_LINK_WIDTH_ACCEPT = 4'd5,
    CFG_LANENUM_WAIT      = 4'd6,
    CFG_LANENUM_ACCEPT    = 4'd7,
    CFG_COMPLETE          = 4'd8,
    CFG_IDLE              = 4'd9,
    L0                    = 4'd10,
    RECOVERY_RCVR_LOCK    = 4'd11,
    RECOVERY_RCVR_CFG     = 4'd12,
    RECOVERY_IDLE         = 4'd13
  } substate_t;

  localparam logic [3:0] LPIF_RESET   = 4'd0;
  localparam logic [3:0] LPIF_ACTIVE  = 4'd1;
  localparam logic [3:0] LPIF_RETRAIN = 4'd2;

  // The one substate an engine may legally ask for next from state s.
  // Returning to detectQuiet is handled separately (always allowed).
  function automatic substate_t successor(input substate_t s);
    substate_t n;
    case (s)
      DETECT_QUIET:          n = DETECT_ACTIVE;
      DETECT_ACTIVE:         n = POLLING_ACTIVE;
      POLLING_ACTIVE:        n = POLLING_CONFIGURATION;
      POLLING_CONFIGURATION: n = CFG_LINK_WIDTH_START;
      CFG_LINK_WIDTH_START:  n = CFG_LINK_WIDTH_ACCEPT;
      CFG_LINK_WIDTH_ACCEPT: n = CFG_LANENUM_WAIT;
      CFG_LANENUM_WAIT:      n = CFG_LANENUM_ACCEPT;
      CFG_LANENUM_ACCEPT:    n = CFG_COMPLETE;
      CFG_COMPLETE:          n = CFG_IDLE;
      CFG_IDLE:              n = L0;
      L0:                    n = RECOVERY_RCVR_LOCK;
      RECOVERY_RCVR_LOCK:    n = RECOVERY_RCVR_CFG;
      RECOVERY_RCVR_CFG:     n = RECOVERY_IDLE;
      RECOVERY_IDLE:         n = L0;
      default:               n = DETECT_QUIET;
    endcase
    return n;
  endfunction

  // Number of set bits in a lane mask (callers zero-extend to 32 bits).
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  // Rate after renegotiation: 1 + index of the highest set bit of
  // rate[max_gen-1:1], or 1 when none is set. Cannot exceed max_gen.
  function automatic logic [2:0] gen_from_rate(input logic [7:0] rate, input int max_gen);
    logic [2:0] g;
    g = 3'd1;
    for (int i = 1; i < 8; i++) begin
      if (i < max_gen && rate[i]) begin
        g = 3'(i + 1);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ltssm_timer.sv
// Stall timer for the LTSSM: counts cycles since the last clear and flags
// expiry once the count reaches TIMEOUT_CYCLES-1. Holds at the final count
// until cleared.
module ltssm_timer #(
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  // Cycle counter, restarted on every clear, saturating at the expiry value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_reg != LAST) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = (count_reg == LAST);

endmodule

// File: rtl/ltssm_ctrl.sv
// Link-level LTSSM controller. Sequences the shared Tx/Rx substate through
// Detect, Polling, Configuration, L0 and Recovery, latches the detected lane
// mask, renegotiates the rate (GEN) in Recovery and stores the link number.
// Optional stall timeouts are built when LTSSM_TIMEOUT_EN is defined.
module ltssm_ctrl
  import ltssm_pkg::*;
#(
  parameter int DEVICETYPE     = 0,
  parameter int LANES          = 16,
  parameter int MAX_GEN        = 3,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 lpifStateRequest,
  input  logic                       finishTx,
  input  logic                       finishRx,
  input  logic [3:0]                 gotoTx,
  input  logic [3:0]                 gotoRx,
  input  logic                       forceDetect,
  input  logic [LANES-1:0]           laneDetected,
  input  logic [7:0]                 rateIdIn,
  input  logic                       writeRateId,
  input  logic [7:0]                 linkNumberIn,
  input  logic                       writeLinkNumber,
  output logic                       linkUp,
  output logic [3:0]                 lpifStateStatus,
  output logic [3:0]                 substateTx,
  output logic [3:0]                 substateRx,
  output logic [LANES-1:0]           activeLanes,
  output logic [$clog2(LANES+1)-1:0] numberOfLanes,
  output logic [2:0]                 GEN,
  output logic [7:0]                 linkNumberOut,
  output logic                       timeoutEvent
);

  localparam int CNT_W = $clog2(LANES + 1);

  substate_t        state_reg, state_next, succ;
  logic             adv, adv_tx, adv_rx, adv_both, goto_quiet;
  logic             load_lanes, load_gen, timeout_hit;
  logic [LANES-1:0] active_reg;
  logic [2:0]       gen_reg;
  logic [7:0]       rate_id_reg, link_number_reg;

  assign succ = successor(state_reg);

  // Next-state logic: handshake qualification, special exits, then overrides
  // that force detectQuiet (engine request, timeout, forceDetect).
  always_comb begin
    state_next = state_reg;
    load_lanes = 1'b0;
    load_gen   = 1'b0;
    adv_tx     = finishTx && (gotoTx == succ);
    adv_rx     = finishRx && (gotoRx == succ);
    adv_both   = adv_tx && adv_rx;
    goto_quiet = (finishTx && gotoTx == DETECT_QUIET) ||
                 (finishRx && gotoRx == DETECT_QUIET);

    // Some configuration substates are driven by the Rx engine alone; on a
    // downstream port the Rx side is passive in cfgLinkWidthAccept.
    case (state_reg)
      CFG_LINK_WIDTH_START,
      CFG_LANENUM_WAIT,
      CFG_LANENUM_ACCEPT:    adv = adv_rx;
      CFG_LINK_WIDTH_ACCEPT: adv = (DEVICETYPE == 0) ? adv_tx : adv_both;
      default:               adv = adv_both;
    endcase

    case (state_reg)
      DETECT_ACTIVE: begin
        if (adv) begin
          load_lanes = 1'b1;
          state_next = (laneDetected == '0) ? DETECT_QUIET : POLLING_ACTIVE;
        end
      end
      CFG_IDLE: begin
        if (adv && lpifStateRequest == LPIF_ACTIVE) begin
          state_next = L0;
        end
      end
      L0: begin
        if (lpifStateRequest == LPIF_RESET) begin
          state_next = DETECT_QUIET;
        end else if (lpifStateRequest == LPIF_RETRAIN ||
                     (finishRx && gotoRx == RECOVERY_RCVR_LOCK)) begin
          state_next = RECOVERY_RCVR_LOCK;
        end
      end
      RECOVERY_RCVR_CFG: begin
        if (adv) begin
          state_next = RECOVERY_IDLE;
          load_gen   = 1'b1;
        end
      end
      default: begin
        if (adv) begin
          state_next = succ;
        end
      end
    endcase

    if (goto_quiet || timeout_hit || forceDetect) begin
      state_next = DETECT_QUIET;
      load_lanes = 1'b0;
      load_gen   = 1'b0;
    end
  end

  // Substate register plus the lane mask and rate that change with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= DETECT_QUIET;
      active_reg <= '0;
      gen_reg    <= 3'd1;
    end else begin
      state_reg <= state_next;
      if (forceDetect) begin
        active_reg <= '0;
        gen_reg    <= 3'd1;
      end else begin
        if (load_lanes) begin
          active_reg <= laneDetected;
        end
        if (load_gen) begin
          gen_reg <= gen_from_rate(rate_id_reg, MAX_GEN);
        end
      end
    end
  end

  // Partner rate and link number registers; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_id_reg     <= '0;
      link_number_reg <= '0;
    end else begin
      if (writeRateId) begin
        rate_id_reg <= rateIdIn;
      end
      if (writeLinkNumber) begin
        link_number_reg <= linkNumberIn;
      end
    end
  end

  // LPIF status and link-up decoded from the registered substate.
  always_comb begin
    lpifStateStatus = LPIF_RESET;
    linkUp          = 1'b0;
    case (state_reg)
      L0: begin
        lpifStateStatus = LPIF_ACTIVE;
        linkUp          = 1'b1;
      end
      RECOVERY_RCVR_LOCK, RECOVERY_RCVR_CFG, RECOVERY_IDLE: begin
        lpifStateStatus = LPIF_RETRAIN;
        linkUp          = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef LTSSM_TIMEOUT_EN
  logic timed, timer_clear, timer_expire, timeout_event_reg;

  // detectQuiet and L0 are resting states and never time out.
  assign timed       = (state_reg != DETECT_QUIET) && (state_reg != L0);
  assign timer_clear = !timed || (state_next != state_reg);
  assign timeout_hit = timed && timer_expire;

  ltssm_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .expire(timer_expire)
  );

  // One-cycle pulse aligned with the timeout exit into detectQuiet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_event_reg <= 1'b0;
    end else begin
      timeout_event_reg <= timeout_hit && !forceDetect;
    end
  end

  assign timeoutEvent = timeout_event_reg;
`else
  assign timeout_hit  = 1'b0;
  assign timeoutEvent = 1'b0;
`endif

  assign substateTx    = state_reg;
  assign substateRx    = state_reg;
  assign activeLanes   = active_reg;
  assign numberOfLanes = CNT_W'(popcount(32'(active_reg)));
  assign GEN           = gen_reg;
  assign linkNumberOut = link_number_reg;

endmodule

// File: tb/tb_ltssm_ctrl.sv
// Directed testbench for ltssm_ctrl: a downstream (u_dut0) and an upstream
// (u_dut1) instance share all stimulus. Timeout checks apply when
// LTSSM_TIMEOUT_EN is defined.
module tb_ltssm_ctrl;

  logic       clk, reset;
  logic [3:0] lpifStateRequest;
  logic       finishTx, finishRx, forceDetect, writeRateId, writeLinkNumber;
  logic [3:0] gotoTx, gotoRx;
  logic [3:0] laneDetected;
  logic [7:0] rateIdIn, linkNumberIn;

  logic       link_up0, link_up1, te0, te1;
  logic [3:0] status0, status1, sub_tx0, sub_tx1, sub_rx0, sub_rx1;
  logic [3:0] lanes0, lanes1;
  logic [2:0] nl0, nl1, gen0, gen1;
  logic [7:0] ln0, ln1;

  int n_checks = 0;
  int n_fails  = 0;

  ltssm_ctrl #(.DEVICETYPE(0), .LANES(4), .MAX_GEN(3), .TIMEOUT_CYCLES(16)) u_dut0 (
    .clk(clk), .reset(reset), .lpifStateRequest(lpifStateRequest),
    .finishTx(finishTx), .finishRx(finishRx), .gotoTx(gotoTx), .gotoRx(gotoRx),
    .forceDetect(forceDetect), .laneDetected(laneDetected),
    .rateIdIn(rateIdIn), .writeRateId(writeRateId),
    .linkNumberIn(linkNumberIn), .writeLinkNumber(writeLinkNumber),
    .linkUp(link_up0), .lpifStateStatus(status0), .substateTx(sub_tx0), .substateRx(sub_rx0),
    .activeLanes(lanes0), .numberOfLanes(nl0), .GEN(gen0), .linkNumberOut(ln0),
    .timeoutEvent(te0)
  );

  ltssm_ctrl #(.DEVICETYPE(1), .LANES(4), .MAX_GEN(3), .TIMEOUT_CYCLES(16)) u_dut1 (
    .clk(clk), .reset(reset), .lpifStateRequest(lpifStateRequest),
    .finishTx(finishTx), .finishRx(finishRx), .gotoTx(gotoTx), .gotoRx(gotoRx),
    .forceDetect(forceDetect), .laneDetected(laneDetected),
    .rateIdIn(rateIdIn), .writeRateId(writeRateId),
    .linkNumberIn(linkNumberIn), .writeLinkNumber(writeLinkNumber),
    .linkUp(link_up1), .lpifStateStatus(status1), .substateTx(sub_tx1), .substateRx(sub_rx1),
    .activeLanes(lanes1), .numberOfLanes(nl1), .GEN(gen1), .linkNumberOut(ln1),
    .timeoutEvent(te1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One engine handshake: strobes held for one clock, called and returning at a negedge.
  task automatic hs(input logic ftx, input logic frx, input logic [3:0] gt, input logic [3:0] gr);
    finishTx = ftx;
    finishRx = frx;
    gotoTx   = gt;
    gotoRx   = gr;
    @(negedge clk);
    finishTx = 1'b0;
    finishRx = 1'b0;
    $display("hs ftx=%0d frx=%0d gotoTx=%0d gotoRx=%0d -> dut0 sub=%0d dut1 sub=%0d status=%0d gen=%0d",
             ftx, frx, gt, gr, sub_tx0, sub_tx1, status0, gen0);
  endtask

  initial begin
    reset = 1'b0;
    lpifStateRequest = 4'd0;
    finishTx = 1'b0; finishRx = 1'b0; gotoTx = 4'd0; gotoRx = 4'd0;
    forceDetect = 1'b0; laneDetected = 4'b1011;
    rateIdIn = 8'h00; writeRateId = 1'b0; linkNumberIn = 8'h00; writeLinkNumber = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_sub", sub_tx0, 4'd0);
    chk("rst_status", status0, 4'd0);
    chk("rst_linkup", link_up0, 1'b0);
    chk("rst_lanes", lanes0, 4'd0);
    chk("rst_gen", gen0, 3'd1);
    chk("rst_te", te0, 1'b0);
    chk("rst_ln", ln0, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_sub", sub_tx0, 4'd0);

    // Link number register write
    linkNumberIn = 8'h5A; writeLinkNumber = 1'b1;
    @(negedge clk);
    writeLinkNumber = 1'b0;
    $display("write linkNumber 5a -> %0h", ln0);
    chk("link_number", ln0, 8'h5A);

    // Test 1: full training, lane mask 1011
    hs(1, 1, 4'd1, 4'd1);  chk("t1_detact", sub_tx0, 4'd1);
    hs(1, 1, 4'd5, 4'd5);  chk("t1_illegal_hold", sub_tx0, 4'd1);
    hs(1, 1, 4'd2, 4'd2);  chk("t1_polling", sub_tx0, 4'd2);
    chk("t1_lanes", lanes0, 4'b1011);
    chk("t1_nlanes", nl0, 3'd3);
    hs(1, 1, 4'd3, 4'd3);
    hs(1, 1, 4'd4, 4'd4);  chk("t1_cfgstart", sub_tx0, 4'd4);
    hs(0, 1, 4'd5, 4'd5);  chk("t1_rxonly_d0", sub_tx0, 4'd5);
    chk("t1_rxonly_d1", sub_tx1, 4'd5);
    hs(1, 1, 4'd6, 4'd6);  chk("t1_lwaccept_d1", sub_tx1, 4'd6);
    hs(0, 1, 4'd7, 4'd7);
    hs(0, 1, 4'd8, 4'd8);
    hs(1, 1, 4'd9, 4'd9);  chk("t1_cfgidle", sub_tx0, 4'd9);
    chk("t1_cfgidle_status", status0, 4'd0);
    hs(1, 1, 4'd10, 4'd10); chk("t1_wait_active", sub_tx0, 4'd9);
    chk("t1_wait_linkup", link_up0, 1'b0);
    lpifStateRequest = 4'd1;
    hs(1, 1, 4'd10, 4'd10); chk("t1_l0", sub_tx0, 4'd10);
    chk("t1_l0_rx", sub_rx0, 4'd10);
    chk("t1_linkup", link_up0, 1'b1);
    chk("t1_status", status0, 4'd1);
    chk("t1_nlanes_l0", nl0, 3'd3);

    // Test 3: retrain with rateId 06 -> GEN 3
    rateIdIn = 8'h06; writeRateId = 1'b1;
    @(negedge clk);
    writeRateId = 1'b0;
    lpifStateRequest = 4'd2;
    @(negedge clk);
    lpifStateRequest = 4'd1;
    $display("retrain request -> sub=%0d status=%0d", sub_tx0, status0);
    chk("t3_lock", sub_tx0, 4'd11);
    chk("t3_lock_status", status0, 4'd2);
    chk("t3_lock_linkup", link_up0, 1'b1);
    hs(0, 1, 4'd12, 4'd12); chk("t3_rxonly_hold", sub_tx0, 4'd11);
    hs(1, 1, 4'd12, 4'd12); chk("t3_rcvrcfg", sub_tx0, 4'd12);
    chk("t3_gen_pre", gen0, 3'd1);
    hs(1, 1, 4'd13, 4'd13); chk("t3_ridle", sub_tx0, 4'd13);
    chk("t3_gen", gen0, 3'd3);
    chk("t3_ridle_status", status0, 4'd2);
    hs(1, 1, 4'd10, 4'd10); chk("t3_back_l0", sub_tx0, 4'd10);
    chk("t3_back_status", status0, 4'd1);

    // Test 5: goto detectQuiet wins over a valid successor
    hs(1, 1, 4'd11, 4'd0); chk("t5_quiet", sub_tx0, 4'd0);
    chk("t5_linkup", link_up0, 1'b0);
    chk("t5_status", status0, 4'd0);

    // Test 2: no lanes detected at detectActive exit
    hs(1, 1, 4'd1, 4'd1);
    laneDetected = 4'b0000;
    hs(1, 1, 4'd2, 4'd2); chk("t2_quiet", sub_tx0, 4'd0);
    chk("t2_lanes", lanes0, 4'd0);
    chk("t2_nlanes", nl0, 3'd0);
    chk("t2_status", status0, 4'd0);

    // Test 4: Tx-only advance in cfgLinkWidthAccept depends on port type
    laneDetected = 4'b1011;
    hs(1, 1, 4'd1, 4'd1);
    hs(1, 1, 4'd2, 4'd2);
    hs(1, 1, 4'd3, 4'd3);
    hs(1, 1, 4'd4, 4'd4);
    hs(0, 1, 4'd5, 4'd5);
    hs(1, 0, 4'd6, 4'd6); chk("t4_dsp_adv", sub_tx0, 4'd6);
    chk("t4_usp_hold", sub_tx1, 4'd5);
    chk("t4_gen_kept", gen0, 3'd3);
    forceDetect = 1'b1;
    @(negedge clk);
    forceDetect = 1'b0;
    $display("forceDetect -> dut0 sub=%0d dut1 sub=%0d gen=%0d", sub_tx0, sub_tx1, gen0);
    chk("t4_force_d0", sub_tx0, 4'd0);
    chk("t4_force_d1", sub_tx1, 4'd0);
    chk("t4_force_gen", gen0, 3'd1);
    chk("t4_force_lanes", lanes0, 4'd0);
    chk("t4_force_ln", ln0, 8'h5A);

    // Test 6: stall in pollingActive
    hs(1, 1, 4'd1, 4'd1);
    hs(1, 1, 4'd2, 4'd2);
`ifdef LTSSM_TIMEOUT_EN
    repeat (15) @(negedge clk);
    chk("t6_still_polling", sub_tx0, 4'd2);
    chk("t6_no_event_yet", te0, 1'b0);
    @(negedge clk);
    $display("timeout -> sub=%0d timeoutEvent=%0d", sub_tx0, te0);
    chk("t6_timeout_quiet", sub_tx0, 4'd0);
    chk("t6_event", te0, 1'b1);
    chk("t6_linkup", link_up0, 1'b0);
    @(negedge clk);
    chk("t6_event_pulse", te0, 1'b0);
`else
    repeat (20) @(negedge clk);
    $display("stall 20 cycles -> sub=%0d timeoutEvent=%0d", sub_tx0, te0);
    chk("t6_hold_polling", sub_tx0, 4'd2);
    chk("t6_no_event", te0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
